load_store_unit: RTL and testbench

- Memory-access stage between execute and register-file write-back.
- Takes the effective address (execute result), store data (reg2) and access size.
- Runs a req/ack handshake to a multi-cycle data memory.
- Holds `stall` to freeze the PC until the access completes, then returns a sign- or zero-extended load result with its destination register.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/load_store_unit_if.sv | 22 ++
 rtl/lsu_align.sv | 52 +++++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and alignment helper for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int unsigned LSU_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } lsu_state_e;

  // Size 3 is reserved and treated as a word access.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~addr_lo[0];
      default: is_aligned = (addr_lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
interface load_store_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enable/data steering and load lane select + extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_wdata,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_st_be    = 4'b1111;
    o_st_wdata = i_st_wdata;
    case (i_st_size)
      SZ_BYTE: begin
        o_st_be    = 4'b0001 << i_st_addr_lo;
        o_st_wdata = {4{i_st_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_st_be    = 4'b0011 << i_st_addr_lo;
        o_st_wdata = {2{i_st_wdata[15:0]}};
      end
      default: begin
        o_st_be    = 4'b1111;
        o_st_wdata = i_st_wdata;
      end
    endcase
  end

  // Shifting the addressed lane down to bit 0 serves both byte and half selects.
  always_comb begin
    w_shifted = i_ld_rdata >> {i_ld_addr_lo, 3'b000};
    w_byte    = w_shifted[7:0];
    w_half    = w_shifted[15:0];
    case (i_ld_size)
      SZ_BYTE: o_ld_data = {{24{~i_ld_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_ld_data = {{16{~i_ld_unsigned & w_half[15]}}, w_half};
      default: o_ld_data = i_ld_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: req/ack handshake to data memory, PC stall, load write-back.
// Optional bus timeout abort is compiled in with `define LSU_TIMEOUT_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic              i_ex_valid,
  input  logic              i_ex_load,
  input  logic              i_ex_store,
  input  logic [1:0]        i_ex_size,
  input  logic              i_ex_unsigned,
  input  logic [ADDR_W-1:0] i_ex_addr,
  input  logic [31:0]       i_ex_wdata,
  input  logic [4:0]        i_ex_wra,
  load_store_unit_if.master bus,
  output logic              o_stall,
  output logic              o_wb_valid,
  output logic [4:0]        o_wb_wra,
  output logic [31:0]       o_wb_data,
  output logic              o_misalign,
  output logic              o_bus_err
);

  lsu_state_e        r_state;
  logic              r_req;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic              r_load;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [1:0]        r_addr_lo;
  logic [4:0]        r_wra;
  logic              r_wb_valid;
  logic [4:0]        r_wb_wra;
  logic [31:0]       r_wb_data;
  logic              r_misalign;

  logic              w_start;
  logic              w_aligned;
  logic [3:0]        w_st_be;
  logic [31:0]       w_st_wdata;
  logic [31:0]       w_ld_data;

  assign w_start   = i_ex_valid & (i_ex_load | i_ex_store);
  assign w_aligned = is_aligned(i_ex_size, i_ex_addr[1:0]);

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned   CntW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] r_tmo_cnt;
  logic            r_bus_err;
  logic            w_tmo;

  assign w_tmo     = ~bus.mem_ack & (r_tmo_cnt == TmoLast);
  assign o_bus_err = r_bus_err;
`else
  assign o_bus_err = 1'b0;
`endif

  lsu_align u_align (
    .i_st_size     (i_ex_size),
    .i_st_addr_lo  (i_ex_addr[1:0]),
    .i_st_wdata    (i_ex_wdata),
    .o_st_be       (w_st_be),
    .o_st_wdata    (w_st_wdata),
    .i_ld_size     (r_size),
    .i_ld_addr_lo  (r_addr_lo),
    .i_ld_unsigned (r_unsigned),
    .i_ld_rdata    (bus.mem_rdata),
    .o_ld_data     (w_ld_data)
  );

  always_ff @(posedge clk) begin
    if (rstd) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_be       <= 4'b0000;
      r_wdata    <= 32'd0;
      r_load     <= 1'b0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_addr_lo  <= 2'd0;
      r_wra      <= 5'd0;
      r_wb_valid <= 1'b0;
      r_wb_wra   <= 5'd0;
      r_wb_data  <= 32'd0;
      r_misalign <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      r_tmo_cnt  <= '0;
      r_bus_err  <= 1'b0;
`endif
    end else begin
      r_wb_valid <= 1'b0;
      r_misalign <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      r_bus_err  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_start && !w_aligned) begin
            r_misalign <= 1'b1;
          end else if (w_start) begin
            r_state    <= BUSY;
            r_req      <= 1'b1;
            r_we       <= ~i_ex_load;
            r_addr     <= {i_ex_addr[ADDR_W-1:2], 2'b00};
            r_be       <= i_ex_load ? 4'b1111 : w_st_be;
            r_wdata    <= w_st_wdata;
            r_load     <= i_ex_load;
            r_size     <= i_ex_size;
            r_unsigned <= i_ex_unsigned;
            r_addr_lo  <= i_ex_addr[1:0];
            r_wra      <= i_ex_wra;
          end
        end
        BUSY: begin
          if (bus.mem_ack) begin
            r_req      <= 1'b0;
            r_state    <= DONE;
            r_wb_valid <= r_load;
            r_wb_wra   <= r_wra;
            r_wb_data  <= w_ld_data;
          end
`ifdef LSU_TIMEOUT_EN
          else if (w_tmo) begin
            r_req     <= 1'b0;
            r_bus_err <= 1'b1;
            r_state   <= DONE;
          end
          if (bus.mem_ack || w_tmo) r_tmo_cnt <= '0;
          else                      r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // The accept cycle stalls combinationally so fetch freezes before the bus cycle starts.
  assign o_stall = (r_state == BUSY) | ((r_state == IDLE) & w_start & w_aligned);

  assign bus.mem_req   = r_req;
  assign bus.mem_we    = r_we;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_be    = r_be;
  assign bus.mem_wdata = r_wdata;

  assign o_wb_valid = r_wb_valid;
  assign o_wb_wra   = r_wb_wra;
  assign o_wb_data  = r_wb_data;
  assign o_misalign = r_misalign;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table plus reset/timeout sequences.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned ADDR_W = 32;
`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TMO = 4;
`else
  localparam int unsigned TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rstd;
  logic        ex_valid, ex_load, ex_store, ex_unsigned;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_wra;
  logic        stall, wb_valid, misalign, bus_err;
  logic [4:0]  wb_wra;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

  load_store_unit #(.TIMEOUT_CYCLES(TMO), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rstd          (rstd),
    .i_ex_valid    (ex_valid),
    .i_ex_load     (ex_load),
    .i_ex_store    (ex_store),
    .i_ex_size     (ex_size),
    .i_ex_unsigned (ex_unsigned),
    .i_ex_addr     (ex_addr),
    .i_ex_wdata    (ex_wdata),
    .i_ex_wra      (ex_wra),
    .bus           (bus),
    .o_stall       (stall),
    .o_wb_valid    (wb_valid),
    .o_wb_wra      (wb_wra),
    .o_wb_data     (wb_data),
    .o_misalign    (misalign),
    .o_bus_err     (bus_err)
  );

  typedef struct {
    string       name;
    bit          load;
    bit          store;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  wra;
    int          waits;
    bit          exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic [4:0]  wra;
    logic [31:0] data;
  } wb_t;

  wb_t sb_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input string n, input bit ld, input bit st, input logic [1:0] sz,
                              input bit u, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input logic [4:0] wra, input int w,
                              input bit mis, input logic [3:0] be, input logic [31:0] ewd,
                              input logic [31:0] ed);
    vec_t v;
    v.name = n; v.load = ld; v.store = st; v.size = sz; v.uns = u; v.addr = a;
    v.wdata = wd; v.rdata = rd; v.wra = wra; v.waits = w; v.exp_mis = mis;
    v.exp_be = be; v.exp_wdata = ewd; v.exp_data = ed;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ex_valid = 1'b1; ex_load = v.load; ex_store = v.store; ex_size = v.size;
    ex_unsigned = v.uns; ex_addr = v.addr; ex_wdata = v.wdata; ex_wra = v.wra;
  endtask

  // Entered and left just after a rising edge.
  task automatic run_vec(input vec_t v);
    int  stalls;
    int  busy;
    bit  done_seen;
    wb_t e;
    drive(v);
    if (!v.exp_mis && v.load) sb_q.push_back('{v.wra, v.exp_data});
    @(negedge clk);
    chk({v.name, "_accept_stall"}, 32'(stall), 32'(!v.exp_mis));
    if (v.exp_mis) begin
      @(posedge clk); #1 ex_valid = 1'b0;
      @(negedge clk);
      chk({v.name, "_misalign"}, 32'(misalign), 32'd1);
      chk({v.name, "_mis_req"}, 32'(bus.mem_req), 32'd0);
      chk({v.name, "_mis_stall"}, 32'(stall), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk({v.name, "_mis_pulse"}, 32'(misalign), 32'd0);
      chk({v.name, "_mis_wbv"}, 32'(wb_valid), 32'd0);
      @(posedge clk); #1;
      return;
    end
    stalls = 1; busy = 0; done_seen = 1'b0;
    for (int cyc = 0; cyc < 64 && !done_seen; cyc++) begin
      @(posedge clk); #1 bus.mem_ack = 1'b0;
      @(negedge clk);
      if (stall) begin
        stalls++;
        chk({v.name, "_req"}, 32'(bus.mem_req), 32'd1);
        if (busy == 0 || busy == v.waits) begin
          chk({v.name, "_we"}, 32'(bus.mem_we), 32'(!v.load));
          chk({v.name, "_addr"}, bus.mem_addr, {v.addr[31:2], 2'b00});
          chk({v.name, "_be"}, 32'(bus.mem_be), 32'(v.exp_be));
          if (!v.load) chk({v.name, "_wdata"}, bus.mem_wdata, v.exp_wdata);
        end
        bus.mem_rdata = (busy == v.waits) ? v.rdata : $urandom;
        bus.mem_ack   = (busy == v.waits);
        busy++;
      end else begin
        done_seen = 1'b1;
        chk({v.name, "_done_req"}, 32'(bus.mem_req), 32'd0);
        chk({v.name, "_wbv"}, 32'(wb_valid), 32'(v.load));
        chk({v.name, "_buserr"}, 32'(bus_err), 32'd0);
        chk({v.name, "_stalls"}, 32'(stalls), 32'(v.waits + 2));
        if (wb_valid) begin
          if (sb_q.size() == 0) begin
            chk({v.name, "_sb_nonempty"}, 32'd0, 32'd1);
          end else begin
            e = sb_q.pop_front();
            chk({v.name, "_wb_wra"}, 32'(wb_wra), 32'(e.wra));
            chk({v.name, "_wb_data"}, wb_data, e.data);
          end
        end
      end
    end
    if (!done_seen) chk({v.name, "_completion_bound"}, 32'd0, 32'd1);
    @(posedge clk); #1 ex_valid = 1'b0; bus.mem_ack = 1'b0;
    @(negedge clk);
    chk({v.name, "_wbv_strobe"}, 32'(wb_valid), 32'd0);
    chk({v.name, "_idle_stall"}, 32'(stall), 32'd0);
    @(posedge clk); #1;
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = mk("lw_10", 1, 0, SZ_WORD, 0, 32'h10, 32'h0, 32'hDEADBEEF, 5'd5, 0, 0,
                  4'b1111, 32'h0, 32'hDEADBEEF);
    vecs[1]  = mk("lb_13", 1, 0, SZ_BYTE, 0, 32'h13, 32'h0, 32'h80FF00FF, 5'd7, 1, 0,
                  4'b1111, 32'h0, 32'hFFFFFF80);
    vecs[2]  = mk("lbu_13", 1, 0, SZ_BYTE, 1, 32'h13, 32'h0, 32'h80FF00FF, 5'd8, 0, 0,
                  4'b1111, 32'h0, 32'h00000080);
    vecs[3]  = mk("sh_22", 0, 1, SZ_HALF, 0, 32'h22, 32'h0000ABCD, 32'h0, 5'd0, 3, 0,
                  4'b1100, 32'hABCDABCD, 32'h0);
    vecs[4]  = mk("lw_02", 1, 0, SZ_WORD, 0, 32'h02, 32'h0, 32'h0, 5'd1, 0, 1,
                  4'b0000, 32'h0, 32'h0);
    vecs[5]  = mk("lh_12", 1, 0, SZ_HALF, 0, 32'h12, 32'h0, 32'h80017FFF, 5'd9, 0, 0,
                  4'b1111, 32'h0, 32'hFFFF8001);
    vecs[6]  = mk("lhu_10", 1, 0, SZ_HALF, 1, 32'h10, 32'h0, 32'h8001F00F, 5'd10, 2, 0,
                  4'b1111, 32'h0, 32'h0000F00F);
    vecs[7]  = mk("sb_41", 0, 1, SZ_BYTE, 0, 32'h41, 32'h123456A5, 32'h0, 5'd0, 2, 0,
                  4'b0010, 32'hA5A5A5A5, 32'h0);
    vecs[8]  = mk("sw_80", 0, 1, SZ_WORD, 0, 32'h80, 32'hCAFEF00D, 32'h0, 5'd0, 0, 0,
                  4'b1111, 32'hCAFEF00D, 32'h0);
    vecs[9]  = mk("lh_11", 1, 0, SZ_HALF, 0, 32'h11, 32'h0, 32'h0, 5'd2, 0, 1,
                  4'b0000, 32'h0, 32'h0);
    vecs[10] = mk("sw_83", 0, 1, SZ_WORD, 0, 32'h83, 32'h11111111, 32'h0, 5'd0, 0, 1,
                  4'b0000, 32'h0, 32'h0);
    vecs[11] = mk("ldst_40", 1, 1, SZ_WORD, 0, 32'h40, 32'hFFFFFFFF, 32'h01234567, 5'd0, 1, 0,
                  4'b1111, 32'h0, 32'h01234567);
    vecs[12] = mk("lsz3_44", 1, 0, 2'd3, 0, 32'h44, 32'h0, 32'h89ABCDEF, 5'd31, 0, 0,
                  4'b1111, 32'h0, 32'h89ABCDEF);
    vecs[13] = mk("lb_21", 1, 0, SZ_BYTE, 0, 32'h21, 32'h0, 32'h00007F00, 5'd4, 0, 0,
                  4'b1111, 32'h0, 32'h0000007F);
    vecs[14] = mk("sh_20", 0, 1, SZ_HALF, 0, 32'h20, 32'hFFFF1234, 32'h0, 5'd0, 1, 0,
                  4'b0011, 32'h12341234, 32'h0);
    vecs[15] = mk("lb_12", 1, 0, SZ_BYTE, 0, 32'h12, 32'h0, 32'h00C30000, 5'd12, 0, 0,
                  4'b1111, 32'h0, 32'hFFFFFFC3);

    rstd = 1'b1; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_size = 2'd0;
    ex_unsigned = 1'b0; ex_addr = 32'h0; ex_wdata = 32'h0; ex_wra = 5'd0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rstd = 1'b0;
    @(negedge clk);
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_be", 32'(bus.mem_be), 32'd0);
    chk("rst_wdata", bus.mem_wdata, 32'd0);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_wbwra", 32'(wb_wra), 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_buserr", 32'(bus_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    // Reset while BUSY abandons the access.
    drive(vecs[0]);
    ex_addr = 32'h30;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstbusy_req", 32'(bus.mem_req), 32'd1);
    @(posedge clk); #1 rstd = 1'b1; ex_valid = 1'b0;
    @(posedge clk); #1 rstd = 1'b0;
    @(negedge clk);
    chk("rstbusy_req_after", 32'(bus.mem_req), 32'd0);
    chk("rstbusy_stall_after", 32'(stall), 32'd0);
    chk("rstbusy_wbv", 32'(wb_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstbusy_wbv_later", 32'(wb_valid), 32'd0);
    @(posedge clk); #1;
    run_vec(vecs[0]);

`ifdef LSU_TIMEOUT_EN
    begin
      int  busy_n;
      bit  ended;
      drive(vecs[0]);
      ex_addr = 32'h50;
      busy_n = 0; ended = 1'b0;
      for (int c = 0; c < 32 && !ended; c++) begin
        @(posedge clk); #1;
        @(negedge clk);
        if (stall) busy_n++;
        else ended = 1'b1;
      end
      chk("tmo_ended", 32'(ended), 32'd1);
      chk("tmo_busy_cycles", 32'(busy_n), 32'(TMO));
      chk("tmo_buserr", 32'(bus_err), 32'd1);
      chk("tmo_req", 32'(bus.mem_req), 32'd0);
      chk("tmo_wbv", 32'(wb_valid), 32'd0);
      @(posedge clk); #1 ex_valid = 1'b0;
      @(negedge clk);
      chk("tmo_buserr_pulse", 32'(bus_err), 32'd0);
      chk("tmo_idle_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      run_vec(vecs[5]);
    end
`endif

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
